// File: rtl/spw_tx_pkg.sv
// Shared SpaceWire TX constants: N-char width, FCT credit quantum and
// the end-to-end credit ceiling, plus the packet terminator codes.
package spw_tx_pkg;

  localparam int unsigned CHAR_W     = 9;
  localparam int unsigned FCT_CREDIT = 8;
  localparam int unsigned MAX_CREDIT = 56;

  localparam logic [CHAR_W-1:0] EOP = 9'h100;
  localparam logic [CHAR_W-1:0] EEP = 9'h101;

endpackage

// File: rtl/spw_tx_credit.sv
// End-to-end TX credit counter: +8 per received FCT, -1 per N-char sent,
// with overflow detection against MAX_CREDIT and a sticky error flag.
module spw_tx_credit
  import spw_tx_pkg::*;
#(
  parameter int unsigned CREDIT_W = 6
) (
  input  logic pclk_tx,
  input  logic enable_tx,
  input  logic send_null_tx,
  input  logic fct_rcvd,
  input  logic pop,
  output logic credit_nz_c,
  output logic credit_err
);

  localparam int unsigned SUM_W = CREDIT_W + 1;

  logic [CREDIT_W-1:0] credit;
  logic [CREDIT_W-1:0] credit_nxt;
  logic [SUM_W-1:0]    grant_sum;
  logic                overflow_c;

  // One extra bit so credit + 8 cannot wrap before the ceiling compare.
  assign grant_sum   = SUM_W'(credit) + SUM_W'(FCT_CREDIT) - SUM_W'(pop);
  assign overflow_c  = fct_rcvd & (grant_sum > SUM_W'(MAX_CREDIT));
  assign credit_nz_c = (credit != '0);

  // An overflowing FCT loses its grant but the pop still takes its credit.
  always_comb begin
    credit_nxt = credit;
    if (send_null_tx) begin
      if (fct_rcvd && !overflow_c) begin
        credit_nxt = CREDIT_W'(grant_sum);
      end else if (pop) begin
        credit_nxt = credit - CREDIT_W'(1);
      end
    end
  end

  always_ff @(posedge pclk_tx or negedge enable_tx) begin
    if (!enable_tx) begin
      credit     <= '0;
      credit_err <= 1'b0;
    end else begin
      credit <= credit_nxt;
      if (send_null_tx && overflow_c) begin
        credit_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_data_queue.sv
// TX staging queue between host writes and the encoder's character scheduler,
// gated by end-to-end FCT credit, plus a held time-code request register.
module tx_data_queue
  import spw_tx_pkg::*;
#(
  parameter int unsigned DATA_W   = CHAR_W,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned CREDIT_W = 6
) (
  input  logic                         pclk_tx,
  input  logic                         enable_tx,
  input  logic                         send_null_tx,
  input  logic                         txwrite_tx,
  input  logic [DATA_W-1:0]            data_tx_i,
  output logic                         ready_tx_o,
  input  logic                         fct_rcvd,
  input  logic                         get_data,
  output logic [DATA_W-1:0]            tx_data_in,
  output logic                         process_data,
  input  logic                         tickin_tx,
  input  logic [7:0]                   timecode_tx_i,
  input  logic                         get_tcode,
  output logic [7:0]                   tx_tcode_in,
  output logic                         tcode_rdy_trnsp,
  output logic                         credit_err,
  output logic [$clog2(DEPTH+1)-1:0]   fill_level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_c;
  logic              pop_c;
  logic              credit_nz_c;

  // Held low while in reset even if the link already reports transmit-capable.
  assign ready_tx_o   = enable_tx & send_null_tx & (fill_level != CNT_W'(DEPTH));
  assign process_data = send_null_tx & (fill_level != '0) & credit_nz_c;
  assign push_c       = txwrite_tx & ready_tx_o;
  assign pop_c        = get_data & process_data;
  assign tx_data_in   = mem[rd_ptr];

  spw_tx_credit #(
    .CREDIT_W (CREDIT_W)
  ) u_credit (
    .pclk_tx      (pclk_tx),
    .enable_tx    (enable_tx),
    .send_null_tx (send_null_tx),
    .fct_rcvd     (fct_rcvd),
    .pop          (pop_c),
    .credit_nz_c  (credit_nz_c),
    .credit_err   (credit_err)
  );

  always_ff @(posedge pclk_tx or negedge enable_tx) begin
    if (!enable_tx) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push_c) begin
      mem[wr_ptr] <= data_tx_i;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge pclk_tx or negedge enable_tx) begin
    if (!enable_tx) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_c, pop_c})
        2'b10:   fill_level <= fill_level + CNT_W'(1);
        2'b01:   fill_level <= fill_level - CNT_W'(1);
        default: fill_level <= fill_level;
      endcase
    end
  end

  // A new tick wins over a same-cycle consume so the fresh code stays pending.
  always_ff @(posedge pclk_tx or negedge enable_tx) begin
    if (!enable_tx) begin
      tx_tcode_in     <= '0;
      tcode_rdy_trnsp <= 1'b0;
    end else if (send_null_tx) begin
      if (tickin_tx) begin
        tx_tcode_in     <= timecode_tx_i;
        tcode_rdy_trnsp <= 1'b1;
      end else if (get_tcode) begin
        tcode_rdy_trnsp <= 1'b0;
      end
    end
  end

endmodule

// File: doc/tx_data_queue.md
# tx_data_queue

Parametrised TX staging block between the host write interface and the SpaceWire TX encoder. Replaces the fixed two-slot data staging with a DEPTH-entry character queue. Adds end-to-end FCT credit tracking, a host-side ready signal and a held time-code request. Sits in the TX path, fed by the host/FIFO side and drained by the encoder's character scheduler.

## Interface
- DATA_W, 9, N-char width: bit 8 = control flag, bits 7:0 = data or EOP/EEP code
- DEPTH, 4, queue entries; power of two, ≥2
- CREDIT_W, 6, credit counter width; must hold MAX_CREDIT = 56
- pclk_tx  in  1  TX clock; single clock domain
- enable_tx  in  1  reset, asynchronous, active-low
- send_null_tx  in  1  link in a transmit-capable state; low freezes all state
- txwrite_tx  in  1  host write strobe
- data_tx_i  in  DATA_W  host character
- ready_tx_o  out  1  queue can accept a write this cycle
- fct_rcvd  in  1  one-cycle pulse: one FCT received; grants 8 credits
- get_data  in  1  encoder consumes head character this cycle
- tx_data_in  out  DATA_W  head character
- process_data  out  1  head valid and credit available
- tickin_tx  in  1  time-code request
- timecode_tx_i  in  8  time-code value
- get_tcode  in  1  encoder consumed the time-code
- tx_tcode_in  out  8  pending time-code
- tcode_rdy_trnsp  out  1  time-code pending
- credit_err  out  1  sticky credit-overflow error
- fill_level  out  $clog2(DEPTH+1)  entries held

## Operation
- Reset (enable_tx=0): queue empty, pointers 0, credit 0, fill_level 0, tx_data_in 0, tx_tcode_in 0, process_data/tcode_rdy_trnsp/credit_err/ready_tx_o 0.
- ready_tx_o = send_null_tx & (fill_level ≠ DEPTH).
- Push = txwrite_tx & ready_tx_o. Writes when not ready are dropped silently.
- process_data = send_null_tx & (fill_level ≠ 0) & (credit ≠ 0).
- Pop = get_data & process_data. get_data while process_data=0 is ignored.
- Every popped N-char (data, EOP, EEP) consumes one credit.
- Credit update per cycle: +8 if fct_rcvd, −1 if pop; both together gives net +7.
- If credit + 8 − pop > 56 on an FCT:
  - increment is discarded; the pop decrement still applies
  - credit_err sets and holds until reset
- Time-code:
  - tickin_tx captures timecode_tx_i and sets tcode_rdy_trnsp.
  - get_tcode clears tcode_rdy_trnsp.
  - tickin_tx and get_tcode in the same cycle: new value captured, flag stays 1.
  - A tick while a code is pending overwrites the value.
- Priority of time-code over data is resolved in the encoder, not here.
- send_null_tx=0: no push, no pop, no tick capture, no credit change. Contents held.

## Timing
- Push at edge k: entry visible in fill_level after edge k.
- Push into an empty queue: tx_data_in and process_data (if credit>0) valid after edge k. Write-to-offer latency is 1 cycle.
- Pop at edge k: next entry appears on tx_data_in after edge k. Back-to-back pops are allowed every cycle.
- Push and pop in the same cycle (queue non-empty, non-full): fill_level unchanged.
- Full queue: ready_tx_o=0. A pop at edge k raises ready_tx_o after edge k.
- Pointers wrap modulo DEPTH.
- tx_data_in is driven from registered storage; there is no combinational path from data_tx_i.
- fct_rcvd at edge k: process_data can rise after edge k.

## Structure
- Shared package spw_tx_pkg holds:
  - CHAR_W=9, FCT_CREDIT=8, MAX_CREDIT=56
  - EOP=9'h100, EEP=9'h101
- Sub-module spw_tx_credit: credit counter with saturation check and credit_err.
- Queue storage and pointers stay in the top level.

## Test plan
- Reset, send_null_tx=1, fct_rcvd once, push 9'h0A5 → after 1 cycle: tx_data_in=9'h0A5, process_data=1; get_data → credit 8→7, fill_level 0.
- Zero credit: push 4 chars with DEPTH=4 → ready_tx_o=0, process_data=0; 5th write dropped; fct_rcvd → 4 consecutive pops in order, credit ends at 4.
- fct_rcvd and pop in the same cycle at credit 3 → credit 10.
- 7 FCTs → credit 56. 8th FCT → credit stays 56, credit_err=1 and sticky.
- tickin_tx with 8'h3F, then tickin_tx with 8'h40 before get_tcode → tx_tcode_in=8'h40, rdy=1; get_tcode → rdy=0.
- Queue holding 2 entries; drop send_null_tx → pushes/pops ignored, fill_level=2. Assert enable_tx=0 mid-operation → all outputs 0 immediately.
